// File: rtl/scan_fault_logger_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : scan_pkg
//  Description : Types, widths and helpers shared by the continuity scanner
//                and the scan fault logger: fault kind encoding, the fault
//                record layout, logger FSM states, and the lowest-set-bit and
//                population-count helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int N_PAIR = 86;     // scanned pin pairs
    localparam int IDX_W  = 7;      // 2**IDX_W >= N_PAIR
    localparam int KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        KIND_OPEN  = 2'd0,          // driven pin read back 1
        KIND_SHORT = 2'd1,          // undriven pin read back 0
        KIND_TRUNC = 2'd2           // stands in for the truncated tail of a step
    } kind_t;

    typedef struct packed {
        kind_t            kind;
        logic [IDX_W-1:0] drive_idx;
        logic [IDX_W-1:0] fault_idx;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty. Scanning from
    // the top down lets the last hit (the lowest bit) win.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_PAIR-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_PAIR - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits; one extra bit of headroom so the caller can detect
    // counts that do not fit in a fault_idx field.
    function automatic logic [IDX_W:0] pop_count(input logic [N_PAIR-1:0] vec);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_PAIR; i++) begin
            cnt = cnt + (IDX_W+1)'(vec[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_fault_logger_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fault_fifo
//  Description : First-word-fall-through FIFO. The head entry is presented on
//                data_o whenever the FIFO is not empty and stays stable until
//                popped. A push into a full FIFO is accepted only if a pop
//                happens in the same cycle. clear_i empties the FIFO and
//                overrides push/pop.
//  Ports       : clk, reset_n (async, active-low), clear_i, push_i/data_i,
//                pop_i, data_o (head, 0 when empty), count_o, full_o, empty_o
//  Revision    : 1.0 - initial release
// ============================================================================
module fault_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16        // power of two
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/scan_fault_logger.sv
`default_nettype none
// ============================================================================
//  Module      : scan_fault_logger
//  Description : Turns each scan step's sampled pin vector into fault
//                records {kind, drive_idx, fault_idx}, one per cycle, buffers
//                them in a FWFT FIFO for the host, and keeps saturating
//                fault / drop / sweep counters plus a sticky fault flag.
//  Ports       : clk, reset_n (async, active-low)
//                step_valid, drive_idx, sample : scan step input
//                clear                         : sync clear of FIFO/counters
//                busy                          : serialiser active
//                rec_valid, rec_ready, rec_data: record output handshake
//                fault_cnt, drop_cnt, sweep_cnt: statistics (saturating)
//                any_fault                     : sticky fault flag
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_fault_logger
    import scan_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int MAX_PER_STEP = 8,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step_valid,
    input  logic [IDX_W-1:0]  drive_idx,
    input  logic [N_PAIR-1:0] sample,
    input  logic              clear,
    output logic              busy,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [REC_W-1:0]  rec_data,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  sweep_cnt,
    output logic              any_fault
);

    localparam int                STEP_W = $clog2(MAX_PER_STEP + 1);
    localparam logic [N_PAIR-1:0] BIT0   = N_PAIR'(1);

    state_t              state_q,     state_d;
    logic [N_PAIR-1:0]   mask_q,      mask_d;
    logic [IDX_W-1:0]    drv_q,       drv_d;
    logic [STEP_W-1:0]   step_cnt_q,  step_cnt_d;
    logic [CNT_W-1:0]    fault_cnt_q, fault_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q,  drop_cnt_d;
    logic [CNT_W-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic                any_fault_q, any_fault_d;

    logic                w_step_ok;
    logic [N_PAIR-1:0]   w_step_mask;
    logic [IDX_W-1:0]    w_low_idx;
    rec_t                w_rec;
    logic                w_gen_push;
    logic                w_gen_fault;
    logic                w_overrun;
    logic [IDX_W:0]      w_trunc_rem;
    logic                w_sweep_hit;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_push_drop;
    logic [CNT_W-1:0]    w_drop_inc;
    logic [$clog2(DEPTH):0] w_fifo_count;
    logic                w_unused_count;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Out-of-range drive positions are not scan steps at all.
    assign w_step_ok   = step_valid && (drive_idx < IDX_W'(N_PAIR));
    // Expected vector is all ones with a zero at the driven position.
    assign w_step_mask = sample ^ ~(BIT0 << drive_idx);
    assign w_low_idx   = lowest_set(mask_q);
    assign w_pop       = rec_valid && rec_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            drv_q       <= '0;
            step_cnt_q  <= '0;
            fault_cnt_q <= '0;
            drop_cnt_q  <= '0;
            sweep_cnt_q <= '0;
            any_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            drv_q       <= drv_d;
            step_cnt_q  <= step_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            sweep_cnt_q <= sweep_cnt_d;
            any_fault_q <= any_fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        drv_d       = drv_q;
        step_cnt_d  = step_cnt_q;
        w_rec       = '0;
        w_gen_push  = 1'b0;
        w_gen_fault = 1'b0;
        w_overrun   = 1'b0;
        w_trunc_rem = '0;
        w_sweep_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_step_ok) begin
                    drv_d       = drive_idx;
                    mask_d      = w_step_mask;
                    step_cnt_d  = '0;
                    w_sweep_hit = (drive_idx == IDX_W'(N_PAIR - 1));
                    if (w_step_mask != '0) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                // A new step cannot be latched mid-serialisation.
                w_overrun  = w_step_ok;
                w_gen_push = 1'b1;
                w_rec.drive_idx = drv_q;
                if (step_cnt_q == STEP_W'(MAX_PER_STEP)) begin
                    // Budget used up: one marker carries the leftover count.
                    w_trunc_rem     = pop_count(mask_q);
                    w_rec.kind      = KIND_TRUNC;
                    w_rec.fault_idx = w_trunc_rem[IDX_W] ? '1 : w_trunc_rem[IDX_W-1:0];
                    mask_d          = '0;
                    state_d         = ST_IDLE;
                end else begin
                    w_gen_fault     = 1'b1;
                    w_rec.kind      = (w_low_idx == drv_q) ? KIND_OPEN : KIND_SHORT;
                    w_rec.fault_idx = w_low_idx;
                    mask_d          = mask_q & ~(BIT0 << w_low_idx);
                    step_cnt_d      = step_cnt_q + STEP_W'(1);
                    if (mask_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A record is lost when the FIFO is full and nothing leaves this cycle.
        w_push_drop = w_gen_push && w_fifo_full && !w_pop;
        w_drop_inc  = CNT_W'(w_overrun) + CNT_W'(w_push_drop) + CNT_W'(w_trunc_rem);

        fault_cnt_d = sat_add(fault_cnt_q, CNT_W'(w_gen_fault));
        drop_cnt_d  = sat_add(drop_cnt_q, w_drop_inc);
        sweep_cnt_d = sat_add(sweep_cnt_q, CNT_W'(w_sweep_hit));
        any_fault_d = any_fault_q || w_gen_fault;

        if (clear) begin
            state_d     = ST_IDLE;
            mask_d      = '0;
            step_cnt_d  = '0;
            fault_cnt_d = '0;
            drop_cnt_d  = '0;
            sweep_cnt_d = '0;
            any_fault_d = 1'b0;
        end
    end

    fault_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (clear),
        .push_i  (w_gen_push && !clear),
        .data_i  (w_rec),
        .pop_i   (rec_ready),
        .data_o  (rec_data),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Fill level is a debug aid of the FIFO; the logger only needs full/empty.
    assign w_unused_count = ^w_fifo_count;

    assign busy      = (state_q == ST_EMIT);
    assign rec_valid = !w_fifo_empty;
    assign fault_cnt = fault_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign sweep_cnt = sweep_cnt_q;
    assign any_fault = any_fault_q;

endmodule
`default_nettype wire
